// File: rtl/wb_slave_pkg.sv
// rtl/wb_slave_pkg.sv - shared FSM state and response-type definitions for wb_slave_mem
package wb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        RETRY = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_ERR  = 2'd2,
        RSP_RTY  = 2'd3
    } resp_e;

endpackage

// File: rtl/wb_slave_mem_if.sv
// rtl/wb_slave_mem_if.sv - Wishbone bus bundle between master and wb_slave_mem
// master drives adr/din/cyc/stb/we/sel; slave drives dout/ack/err/rty/eod.
interface wb_slave_mem_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic [AWIDTH-1:0]   adr;
    logic [DWIDTH-1:0]   din;
    logic [DWIDTH-1:0]   dout;
    logic                cyc;
    logic                stb;
    logic                we;
    logic [DWIDTH/8-1:0] sel;
    logic                ack;
    logic                err;
    logic                rty;
    logic                eod;

    modport master (
        output adr, din, cyc, stb, we, sel,
        input  dout, ack, err, rty, eod
    );

    modport slave (
        input  adr, din, cyc, stb, we, sel,
        output dout, ack, err, rty, eod
    );
endinterface

// File: rtl/wb_slave_ram.sv
// rtl/wb_slave_ram.sv - single-port synchronous RAM with per-byte write enables
// Ports: clk; be (byte write enables); addr (word index); wdata; rdata (registered read).
module wb_slave_ram #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                clk,
    input  logic [DWIDTH/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DWIDTH-1:0]   wdata,
    output logic [DWIDTH-1:0]   rdata
);
    logic [DWIDTH-1:0] mem [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DWIDTH/8; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/wb_slave_mem.sv
// rtl/wb_slave_mem.sv - Wishbone slave memory with wait states, retry injection and range errors
// Ports: clk, rst (sync active-high); bus (slave modport: adr/din/cyc/stb/we/sel in,
// dout/ack/err/rty/eod out); wait_cyc (wait states per response); rty_once (arms one retry).
module wb_slave_mem
    import wb_slave_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_slave_mem_if.slave        bus,
    input  logic [3:0]           wait_cyc,
    input  logic                 rty_once
);
    localparam int NBYTES = DWIDTH / 8;
    localparam int OFFSET = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int RAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic [RAW-1:0]      index_q, index_d;
    logic                in_range_q, in_range_d;
    logic                eod_q, eod_d;
    logic                we_q, we_d;
    logic [NBYTES-1:0]   sel_q, sel_d;
    logic [DWIDTH-1:0]   din_q, din_d;

    logic [AWIDTH-1:0]   word_idx;
    logic                req;
    logic                hit_in_range;
    logic                hit_last;
    logic [NBYTES-1:0]   ram_be;
    logic [RAW-1:0]      ram_addr;
    logic [DWIDTH-1:0]   ram_rdata;
    resp_e               resp;

    assign word_idx     = bus.adr >> OFFSET;
    assign req          = bus.cyc & bus.stb;
    assign hit_in_range = word_idx < AWIDTH'(DEPTH);
    assign hit_last     = word_idx == AWIDTH'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            index_q    <= '0;
            in_range_q <= 1'b0;
            eod_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            index_q    <= index_d;
            in_range_q <= in_range_d;
            eod_q      <= eod_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            din_q      <= din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        // A pulse in any cycle arms; consuming the arm below lets a pulse in the same cycle win.
        armed_d    = armed_q | rty_once;
        index_d    = index_q;
        in_range_d = in_range_q;
        eod_d      = eod_q;
        we_d       = we_q;
        sel_d      = sel_q;
        din_d      = din_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (armed_q) begin
                        state_d = RETRY;
                        armed_d = rty_once;
                    end else if (wait_cyc == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = wait_cyc - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            RETRY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Request attributes are frozen on the edge entering RESP.
        if (state_d == RESP && state_q != RESP) begin
            index_d    = word_idx[RAW-1:0];
            in_range_d = hit_in_range;
            eod_d      = hit_last;
            we_d       = bus.we;
            sel_d      = bus.sel;
            din_d      = bus.din;
        end
    end

    always_comb begin
        resp = RSP_NONE;
        case (state_q)
            RESP:    resp = in_range_q ? RSP_ACK : RSP_ERR;
            RETRY:   resp = RSP_RTY;
            default: resp = RSP_NONE;
        endcase
        bus.ack  = (resp == RSP_ACK);
        bus.err  = (resp == RSP_ERR);
        bus.rty  = (resp == RSP_RTY);
        bus.eod  = (resp == RSP_ACK) & eod_q;
        bus.dout = (resp == RSP_ACK) ? ram_rdata : '0;
    end

    // Outside RESP the RAM is addressed by the live bus so read data is ready on RESP entry;
    // during RESP it holds the captured index for the write.
    assign ram_addr = (state_q == RESP) ? index_q : word_idx[RAW-1:0];
    assign ram_be   = (state_q == RESP && in_range_q && we_q && !rst) ? sel_q : '0;

    wb_slave_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (RAW)
    ) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (din_q),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_wb_slave_mem.sv
// tb/tb_wb_slave_mem.sv - self-checking scoreboard bench for wb_slave_mem
module tb_wb_slave_mem;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;

    typedef struct {
        int          kind;      // 1 ack, 2 err, 3 rty
        logic [31:0] data;
        logic        chk_data;
        logic        eod;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wait_cyc;
    logic       rty_once;

    exp_t        sbq[$];
    logic [31:0] model [DEPTH];
    logic        armed_m;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    wb_slave_mem_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    wb_slave_mem #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .wait_cyc (wait_cyc),
        .rty_once (rty_once)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.sel = '0;   bus.adr = '0;   bus.din = '0;
    endtask

    function automatic logic [3:0] outs();
        return {bus.ack, bus.err, bus.rty, bus.eod};
    endfunction

    task automatic pulse_rty();
        rty_once = 1'b1;
        @(posedge clk); #1;
        rty_once = 1'b0;
        armed_m  = 1'b1;
    endtask

    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   idx;
        int   n;
        logic got;
        idx = int'(a >> 2);
        if (armed_m) begin
            e.kind = 3; armed_m = 1'b0;
        end else if (idx < DEPTH) begin
            e.kind = 1;
        end else begin
            e.kind = 2;
        end
        e.lat      = (e.kind == 3) ? 1 : int'(wait_cyc) + 1;
        e.eod      = (e.kind == 1) && (idx == DEPTH - 1);
        e.chk_data = !w || e.kind != 1;
        e.data     = (e.kind == 1 && !w) ? model[idx] : 32'h0;
        sbq.push_back(e);
        if (e.kind == 1 && w) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        end
        bus.adr = a; bus.we = w; bus.din = d; bus.sel = s;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        got = 1'b0; n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.ack || bus.err || bus.rty) begin
                n = i; got = 1'b1; break;
            end
            chk("dout_zero_wait", bus.dout, 32'h0);
        end
        bus.cyc = 1'b0; bus.stb = 1'b0;
        chk("resp_seen", {31'h0, got}, 32'h1);
        if (got) begin
            e = sbq.pop_front();
            chk("latency", n, e.lat);
            chk("ack", {31'h0, bus.ack}, {31'h0, e.kind == 1});
            chk("err", {31'h0, bus.err}, {31'h0, e.kind == 2});
            chk("rty", {31'h0, bus.rty}, {31'h0, e.kind == 3});
            chk("eod", {31'h0, bus.eod}, {31'h0, e.eod});
            if (e.chk_data) chk("dout", bus.dout, e.data);
        end
        @(posedge clk); #1;
        chk("resp_not_repeated", {28'h0, outs()}, 32'h0);
        chk("dout_zero_after", bus.dout, 32'h0);
    endtask

    initial begin
        int resp_cnt;
        int first_at;
        int second_at;
        exp_t e;

        rst = 1'b1; wait_cyc = 4'd0; rty_once = 1'b0; armed_m = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {28'h0, outs()}, 32'h0);
        chk("reset_dout", bus.dout, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // zero wait: write then read
        txn(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        txn(32'h10, 1'b0, 32'h0, 4'hF);

        // partial byte-lane write over preload
        txn(32'h20, 1'b1, 32'h11223344, 4'hF);
        txn(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101);
        txn(32'h20, 1'b0, 32'h0, 4'hF);
        chk("byte_lane_model", model[8], 32'h11BB33DD);

        // wait states
        txn(32'h0, 1'b1, 32'hCAFEF00D, 4'hF);
        wait_cyc = 4'd3;
        txn(32'h0, 1'b0, 32'h0, 4'hF);
        wait_cyc = 4'd0;

        // range boundary: out-of-range write errors and corrupts nothing, last word gives eod
        txn(32'hFFC, 1'b1, 32'h0BADC0DE, 4'hF);
        txn(32'h1000, 1'b1, 32'h99999999, 4'hF);
        txn(32'h0, 1'b0, 32'h0, 4'hF);
        txn(32'hFFC, 1'b0, 32'h0, 4'hF);
        txn(32'h1000, 1'b0, 32'h0, 4'hF);

        // armed retry suppresses the write; reissue succeeds
        txn(32'h8, 1'b1, 32'h00000077, 4'hF);
        pulse_rty();
        txn(32'h8, 1'b1, 32'h00000005, 4'hF);
        txn(32'h8, 1'b0, 32'h0, 4'hF);
        txn(32'h8, 1'b1, 32'h00000005, 4'hF);
        txn(32'h8, 1'b0, 32'h0, 4'hF);

        // abort in WAIT: no response, no write
        wait_cyc = 4'd3;
        bus.adr = 32'h20; bus.we = 1'b1; bus.din = 32'hFFFFFFFF; bus.sel = 4'hF;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        @(posedge clk); #1;
        bus.stb = 1'b0; bus.cyc = 1'b0;
        resp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.ack || bus.err || bus.rty) resp_cnt++;
        end
        chk("abort_no_resp", resp_cnt, 0);
        wait_cyc = 4'd0;
        txn(32'h20, 1'b0, 32'h0, 4'hF);

        // reset in the second WAIT cycle of a write
        wait_cyc = 4'd5;
        bus.adr = 32'h10; bus.we = 1'b1; bus.din = 32'h12345678; bus.sel = 4'hF;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_wait1", {28'h0, outs()}, 32'h0);
        @(posedge clk); #1;
        chk("rst_pre_wait2", {28'h0, outs()}, 32'h0);
        rst = 1'b1;
        idle_bus();
        @(posedge clk); #1;
        chk("rst_mid_outs", {28'h0, outs()}, 32'h0);
        chk("rst_mid_dout", bus.dout, 32'h0);
        rst = 1'b0;
        wait_cyc = 4'd0;
        txn(32'h10, 1'b0, 32'h0, 4'hF);

        // back-to-back reads with stb held through the ack
        e.kind = 1; e.data = model[4]; e.chk_data = 1'b1; e.eod = 1'b0; e.lat = 1;
        sbq.push_back(e);
        e.data = model[8];
        sbq.push_back(e);
        bus.adr = 32'h10; bus.we = 1'b0; bus.sel = 4'hF;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        resp_cnt = 0; first_at = 0; second_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus.ack || bus.err || bus.rty) begin
                resp_cnt++;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("b2b_ack", {31'h0, bus.ack}, 32'h1);
                    chk("b2b_dout", bus.dout, e.data);
                end
                if (resp_cnt == 1) begin
                    first_at = i;
                    bus.adr = 32'h20;
                end else begin
                    second_at = i;
                    bus.cyc = 1'b0; bus.stb = 1'b0;
                    break;
                end
            end
        end
        bus.cyc = 1'b0; bus.stb = 1'b0;
        chk("b2b_count", resp_cnt, 2);
        chk("b2b_first", first_at, 1);
        chk("b2b_gap", second_at - first_at, 2);
        @(posedge clk); #1;
        chk("b2b_quiet", {28'h0, outs()}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
